ibex_pmp_checker_pipe: RTL and testbench

Registered, handshaked PMP access checker that generalises the core's combinational PMP check to N channels with valid/ready flow control, one-cycle latency, matched-region reporting and a sticky fault log with per-channel fault counters. It sits between the fetch/LSU request paths and the memory interface. Requests are checked against the live PMP CSR state, and results are held until the consumer accepts them.

---
 rtl/ibex_pkg.sv | 47 ++++
 rtl/ibex_pmp_chan_check.sv | 135 +++++++++++++
 rtl/ibex_pmp_checker_pipe.sv | 143 ++++++++++++++
 tb/tb_ibex_pmp_checker_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// PMP types shared by the PMP checkers: privilege levels, access types, region config.
// Combinational-only content; no latency or backpressure of its own.
package ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    localparam int unsigned PMP_MAX_REGIONS = 16;

    function automatic int unsigned pmp_region_idx_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : unsigned'($clog2(n));
    endfunction

    localparam int unsigned PMP_REGION_W = pmp_region_idx_w(PMP_MAX_REGIONS);

endpackage

// File: rtl/ibex_pmp_chan_check.sv
// Combinational PMP check for one access channel: region match, permission, priority.
// Zero latency, no handshake; the caller registers the result.
module ibex_pmp_chan_check
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 16,
    parameter logic [31:0] DmBaseAddr     = 32'h1A110000,
    parameter logic [31:0] DmAddrMask     = 32'h00000FFF
) (
    input  pmp_cfg_t                 csr_pmp_cfg  [PMPNumRegions],
    input  logic [33:0]              csr_pmp_addr [PMPNumRegions],
    input  pmp_mseccfg_t             csr_pmp_mseccfg,
    input  logic                     debug_mode,
    input  logic [33:0]              req_addr,
    input  pmp_req_e                 req_type,
    input  priv_lvl_e                req_priv,
    output logic                     err,
    output logic                     matched,
    output logic [PMP_REGION_W-1:0]  region
);

    localparam int          GranLsb  = int'(PMPGranularity) + 2;
    localparam int          LoBit    = (PMPGranularity == 0) ? 2 : int'(PMPGranularity) + 1;
    localparam logic [33:0] GranMask = {34{1'b1}} << GranLsb;

    // Bits that take part in the NA4/NAPOT equality; NAPOT drops the trailing-ones run.
    function automatic logic [33:0] match_mask(input logic [33:0] addr, input logic napot);
        logic [33:0] mask;
        logic        run;
        mask = '0;
        run  = 1'b1;
        for (int b = GranLsb; b < 34; b++) begin
            if (b - 1 >= LoBit) begin
                run = run & addr[b-1];
            end
            if (PMPGranularity == 0 && b == 2) begin
                mask[b] = ~napot;
            end else begin
                mask[b] = ~napot | ~run;
            end
        end
        return mask;
    endfunction

    logic [33:0]              prev_addr [PMPNumRegions];
    logic [PMPNumRegions-1:0] region_match;
    logic [PMPNumRegions-1:0] region_perm;
    pmp_cfg_t                 cfg_r;
    logic                     perm_bit;
    logic                     perm_ok;
    logic                     is_exec, is_write, is_read, is_m;
    logic                     hit_perm;
    logic                     deny;
    logic                     dm_access;
    logic                     unused_rlb;

    assign unused_rlb = csr_pmp_mseccfg.rlb;

    assign is_exec  = (req_type == PMP_ACC_EXEC);
    assign is_write = (req_type == PMP_ACC_WRITE);
    assign is_read  = (req_type == PMP_ACC_READ);
    assign is_m     = (req_priv == PRIV_LVL_M);

    always_comb begin
        prev_addr[0] = '0;
        for (int r = 1; r < int'(PMPNumRegions); r++) begin
            prev_addr[r] = csr_pmp_addr[r-1];
        end
    end

    always_comb begin
        for (int r = 0; r < int'(PMPNumRegions); r++) begin
            region_match[r] = 1'b0;
            case (csr_pmp_cfg[r].mode)
                PMP_MODE_OFF: region_match[r] = 1'b0;
                PMP_MODE_TOR: region_match[r] =
                    ((req_addr & GranMask) >= (prev_addr[r] & GranMask)) &&
                    ((req_addr & GranMask) <  (csr_pmp_addr[r] & GranMask));
                default: region_match[r] =
                    (((req_addr ^ csr_pmp_addr[r]) &
                      match_mask(csr_pmp_addr[r], csr_pmp_cfg[r].mode == PMP_MODE_NAPOT)) == '0);
            endcase
        end
    end

    always_comb begin
        cfg_r    = '0;
        perm_bit = 1'b0;
        perm_ok  = 1'b0;
        for (int r = 0; r < int'(PMPNumRegions); r++) begin
            cfg_r    = csr_pmp_cfg[r];
            perm_bit = (is_exec & cfg_r.exec) | (is_write & cfg_r.write) | (is_read & cfg_r.read);
            if (csr_pmp_mseccfg.mml) begin
                // R=0/W=1 encodes the Smepmp shared-region table instead of plain RWX
                if (!cfg_r.read && cfg_r.write) begin
                    case ({cfg_r.lock, cfg_r.exec})
                        2'b00:   perm_ok = is_read | (is_write & is_m);
                        2'b01:   perm_ok = is_read | is_write;
                        2'b10:   perm_ok = is_exec;
                        default: perm_ok = is_exec | (is_read & is_m);
                    endcase
                end else if (cfg_r.read & cfg_r.write & cfg_r.exec & cfg_r.lock) begin
                    perm_ok = is_read;
                end else begin
                    perm_ok = perm_bit & (is_m ? cfg_r.lock : ~cfg_r.lock);
                end
            end else begin
                perm_ok = is_m ? (~cfg_r.lock | perm_bit) : perm_bit;
            end
            region_perm[r] = perm_ok;
        end
    end

    always_comb begin
        matched  = 1'b0;
        region   = '0;
        hit_perm = 1'b0;
        for (int r = int'(PMPNumRegions) - 1; r >= 0; r--) begin
            if (region_match[r]) begin
                matched  = 1'b1;
                region   = PMP_REGION_W'(r);
                hit_perm = region_perm[r];
            end
        end
        if (matched) begin
            deny = ~hit_perm;
        end else begin
            deny = csr_pmp_mseccfg.mmwp | ~is_m | (csr_pmp_mseccfg.mml & is_exec);
        end
        dm_access = debug_mode && ((req_addr[31:0] & ~DmAddrMask) == DmBaseAddr);
        err       = deny & ~dm_access;
    end

endmodule

// File: rtl/ibex_pmp_checker_pipe.sv
// N-channel registered PMP checker with matched-region report, sticky fault log and fault counters.
// One-cycle latency; each channel holds its response until rsp_ready_i, stalling req_ready_o.
module ibex_pmp_checker_pipe
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumChan     = 2,
    parameter int unsigned PMPNumRegions  = 16,
    parameter logic [31:0] DmBaseAddr     = 32'h1A110000,
    parameter logic [31:0] DmAddrMask     = 32'h00000FFF,
    parameter int unsigned FaultCntWidth  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  pmp_cfg_t                  csr_pmp_cfg_i  [PMPNumRegions],
    input  logic [33:0]               csr_pmp_addr_i [PMPNumRegions],
    input  pmp_mseccfg_t              csr_pmp_mseccfg_i,
    input  logic                      debug_mode_i,
    input  logic [PMPNumChan-1:0]     req_valid_i,
    output logic [PMPNumChan-1:0]     req_ready_o,
    input  logic [33:0]               req_addr_i [PMPNumChan],
    input  pmp_req_e                  req_type_i [PMPNumChan],
    input  priv_lvl_e                 req_priv_i [PMPNumChan],
    output logic [PMPNumChan-1:0]     rsp_valid_o,
    input  logic [PMPNumChan-1:0]     rsp_ready_i,
    output logic [PMPNumChan-1:0]     rsp_err_o,
    output logic [PMPNumChan-1:0]     rsp_matched_o,
    output logic [PMP_REGION_W-1:0]   rsp_region_o [PMPNumChan],
    output logic                      fault_valid_o,
    output logic [33:0]               fault_addr_o,
    output logic [2:0]                fault_chan_o,
    output pmp_req_e                  fault_type_o,
    output logic [FaultCntWidth-1:0]  fault_cnt_o [PMPNumChan],
    input  logic                      fault_clear_i
);

    logic [PMPNumChan-1:0]   chk_err;
    logic [PMPNumChan-1:0]   chk_matched;
    logic [PMP_REGION_W-1:0] chk_region [PMPNumChan];
    logic [PMPNumChan-1:0]   fault_hit;
    logic                    new_fault;
    logic [2:0]              new_chan;
    logic [33:0]             new_addr;
    pmp_req_e                new_type;

    for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
        ibex_pmp_chan_check #(
            .PMPGranularity (PMPGranularity),
            .PMPNumRegions  (PMPNumRegions),
            .DmBaseAddr     (DmBaseAddr),
            .DmAddrMask     (DmAddrMask)
        ) u_check (
            .csr_pmp_cfg     (csr_pmp_cfg_i),
            .csr_pmp_addr    (csr_pmp_addr_i),
            .csr_pmp_mseccfg (csr_pmp_mseccfg_i),
            .debug_mode      (debug_mode_i),
            .req_addr        (req_addr_i[c]),
            .req_type        (req_type_i[c]),
            .req_priv        (req_priv_i[c]),
            .err             (chk_err[c]),
            .matched         (chk_matched[c]),
            .region          (chk_region[c])
        );
    end

    assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
    assign fault_hit   = req_valid_i & req_ready_o & chk_err;

    // Descending scan so the lowest faulting channel is the one recorded.
    always_comb begin
        new_fault = 1'b0;
        new_chan  = '0;
        new_addr  = '0;
        new_type  = PMP_ACC_EXEC;
        for (int c = int'(PMPNumChan) - 1; c >= 0; c--) begin
            if (fault_hit[c]) begin
                new_fault = 1'b1;
                new_chan  = 3'(c);
                new_addr  = req_addr_i[c];
                new_type  = req_type_i[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o   <= '0;
            rsp_err_o     <= '0;
            rsp_matched_o <= '0;
            for (int c = 0; c < int'(PMPNumChan); c++) begin
                rsp_region_o[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(PMPNumChan); c++) begin
                if (req_ready_o[c]) begin
                    rsp_valid_o[c] <= req_valid_i[c];
                    if (req_valid_i[c]) begin
                        rsp_err_o[c]     <= chk_err[c];
                        rsp_matched_o[c] <= chk_matched[c];
                        rsp_region_o[c]  <= chk_region[c];
                    end
                end
            end
        end
    end

    // A clear coinciding with a new fault leaves the new fault logged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            fault_chan_o  <= '0;
            fault_type_o  <= PMP_ACC_EXEC;
        end else if (new_fault && (!fault_valid_o || fault_clear_i)) begin
            fault_valid_o <= 1'b1;
            fault_addr_o  <= new_addr;
            fault_chan_o  <= new_chan;
            fault_type_o  <= new_type;
        end else if (fault_clear_i) begin
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            fault_chan_o  <= '0;
            fault_type_o  <= PMP_ACC_EXEC;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < int'(PMPNumChan); c++) begin
                fault_cnt_o[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(PMPNumChan); c++) begin
                if (fault_clear_i) begin
                    fault_cnt_o[c] <= fault_hit[c] ? FaultCntWidth'(1) : '0;
                end else if (fault_hit[c] && (fault_cnt_o[c] != '1)) begin
                    fault_cnt_o[c] <= fault_cnt_o[c] + FaultCntWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_pmp_checker_pipe.sv
// Bench for ibex_pmp_checker_pipe: per-channel expected-response queues drained by a monitor,
// plus directed checks of the fault log, counters, hold behaviour and reset.
module tb_ibex_pmp_checker_pipe;
    import ibex_pkg::*;

    localparam int NCH  = 2;
    localparam int NREG = 16;

    logic           clk_i  = 1'b0;
    logic           rst_ni = 1'b0;
    pmp_cfg_t       cfg   [NREG];
    logic [33:0]    paddr [NREG];
    pmp_mseccfg_t   msec;
    logic           dbg;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_ready;
    logic [33:0]    req_addr [NCH];
    pmp_req_e       req_type [NCH];
    priv_lvl_e      req_priv [NCH];
    logic [NCH-1:0] rsp_valid;
    logic [NCH-1:0] rsp_ready;
    logic [NCH-1:0] rsp_err;
    logic [NCH-1:0] rsp_matched;
    logic [3:0]     rsp_region [NCH];
    logic           fault_valid;
    logic [33:0]    fault_addr;
    logic [2:0]     fault_chan;
    pmp_req_e       fault_type;
    logic [7:0]     fault_cnt [NCH];
    logic           fault_clear;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    always #5 clk_i = ~clk_i;

    ibex_pmp_checker_pipe dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .csr_pmp_cfg_i     (cfg),
        .csr_pmp_addr_i    (paddr),
        .csr_pmp_mseccfg_i (msec),
        .debug_mode_i      (dbg),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_type_i        (req_type),
        .req_priv_i        (req_priv),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_err_o         (rsp_err),
        .rsp_matched_o     (rsp_matched),
        .rsp_region_o      (rsp_region),
        .fault_valid_o     (fault_valid),
        .fault_addr_o      (fault_addr),
        .fault_chan_o      (fault_chan),
        .fault_type_o      (fault_type),
        .fault_cnt_o       (fault_cnt),
        .fault_clear_i     (fault_clear)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected response word is {err, matched, region[3:0]}.
    always @(negedge clk_i) begin
        if (rsp_valid[0] && rsp_ready[0]) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp0_unexpected: got response 0x%0h with no expected entry",
                         {rsp_err[0], rsp_matched[0], rsp_region[0]});
            end else begin
                chk("rsp0", {rsp_err[0], rsp_matched[0], rsp_region[0]}, q0.pop_front());
            end
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp1_unexpected: got response 0x%0h with no expected entry",
                         {rsp_err[1], rsp_matched[1], rsp_region[1]});
            end else begin
                chk("rsp1", {rsp_err[1], rsp_matched[1], rsp_region[1]}, q1.pop_front());
            end
        end
    end

    task automatic issue(input int c, input logic [33:0] a, input pmp_req_e t, input priv_lvl_e p,
                         input logic e, input logic m, input logic [3:0] r);
        req_valid[c] = 1'b1;
        req_addr[c]  = a;
        req_type[c]  = t;
        req_priv[c]  = p;
        if (c == 0) q0.push_back({e, m, r});
        else        q1.push_back({e, m, r});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        req_valid   = '0;
        fault_clear = 1'b0;
    endtask

    task automatic setcfg(input int r, input logic l, input pmp_cfg_mode_e md, input logic x,
                          input logic w, input logic rd, input logic [33:0] a);
        cfg[r]   = '{lock: l, mode: md, exec: x, write: w, read: rd};
        paddr[r] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < NREG; r++) setcfg(r, 0, PMP_MODE_OFF, 0, 0, 0, 34'h0);
        msec        = '0;
        dbg         = 1'b0;
        req_valid   = '0;
        rsp_ready   = '1;
        fault_clear = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            req_addr[c] = '0;
            req_type[c] = PMP_ACC_READ;
            req_priv[c] = PRIV_LVL_M;
        end

        #2;
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_req_ready", req_ready, 2'b11);
        chk("reset_fault_valid", fault_valid, 0);
        chk("reset_fault_addr", fault_addr, 0);
        chk("reset_cnt0", fault_cnt[0], 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // NAPOT 0x1000-0x1FFF, read-only
        setcfg(0, 0, PMP_MODE_NAPOT, 0, 0, 1, 34'h17FC);
        issue(0, 34'h1800, PMP_ACC_READ, PRIV_LVL_U, 0, 1, 0);
        issue(1, 34'h5000, PMP_ACC_READ, PRIV_LVL_M, 0, 0, 0);
        step();
        chk("napot_no_fault_yet", fault_valid, 0);
        issue(0, 34'h1800, PMP_ACC_WRITE, PRIV_LVL_U, 1, 1, 0);
        step();
        chk("napot_fault_valid", fault_valid, 1);
        chk("napot_fault_addr", fault_addr, 34'h1800);
        chk("napot_fault_chan", fault_chan, 0);
        chk("napot_fault_type", fault_type, PMP_ACC_WRITE);
        chk("napot_cnt0", fault_cnt[0], 1);

        // TOR 0x2000-0x2FFF, locked, not readable
        fault_clear = 1'b1;
        step();
        chk("clear_fault_valid", fault_valid, 0);
        chk("clear_cnt0", fault_cnt[0], 0);
        setcfg(0, 0, PMP_MODE_OFF, 0, 0, 0, 34'h2000);
        setcfg(1, 1, PMP_MODE_TOR, 1, 1, 0, 34'h3000);
        issue(0, 34'h2FFC, PMP_ACC_READ, PRIV_LVL_M, 1, 1, 1);
        issue(1, 34'h3000, PMP_ACC_READ, PRIV_LVL_M, 0, 0, 0);
        step();
        chk("tor_fault_addr", fault_addr, 34'h2FFC);
        chk("tor_fault_type", fault_type, PMP_ACC_READ);
        issue(0, 34'h2000, PMP_ACC_WRITE, PRIV_LVL_M, 0, 1, 1);
        issue(1, 34'h1FFC, PMP_ACC_READ, PRIV_LVL_U, 1, 0, 0);
        step();
        chk("tor_log_sticky", fault_addr, 34'h2FFC);

        // Smepmp: R=0 W=1 L=1 X=0 is execute-only shared
        msec = '{rlb: 0, mmwp: 0, mml: 1};
        setcfg(1, 0, PMP_MODE_OFF, 0, 0, 0, 34'h0);
        setcfg(0, 1, PMP_MODE_NAPOT, 0, 1, 0, 34'h17FC);
        issue(0, 34'h1100, PMP_ACC_EXEC, PRIV_LVL_S, 0, 1, 0);
        issue(1, 34'h1100, PMP_ACC_READ, PRIV_LVL_M, 1, 1, 0);
        step();
        issue(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_M, 1, 0, 0);
        issue(1, 34'h8000, PMP_ACC_READ, PRIV_LVL_M, 0, 0, 0);
        step();
        msec = '{rlb: 0, mmwp: 1, mml: 1};
        issue(1, 34'h8000, PMP_ACC_READ, PRIV_LVL_M, 1, 0, 0);
        step();
        msec = '{rlb: 0, mmwp: 0, mml: 1};
        setcfg(0, 1, PMP_MODE_NAPOT, 1, 1, 1, 34'h17FC);
        issue(0, 34'h1100, PMP_ACC_WRITE, PRIV_LVL_M, 1, 1, 0);
        issue(1, 34'h1100, PMP_ACC_READ, PRIV_LVL_U, 0, 1, 0);
        step();
        chk("mml_cnt0", fault_cnt[0], 3);
        chk("mml_cnt1", fault_cnt[1], 3);

        // Same-cycle faults and clear-with-fault
        msec = '0;
        setcfg(0, 0, PMP_MODE_NAPOT, 0, 0, 1, 34'h17FC);
        fault_clear = 1'b1;
        step();
        issue(0, 34'h1004, PMP_ACC_WRITE, PRIV_LVL_U, 1, 1, 0);
        issue(1, 34'h1008, PMP_ACC_WRITE, PRIV_LVL_U, 1, 1, 0);
        step();
        chk("dual_fault_chan", fault_chan, 0);
        chk("dual_fault_addr", fault_addr, 34'h1004);
        chk("dual_cnt0", fault_cnt[0], 1);
        chk("dual_cnt1", fault_cnt[1], 1);
        fault_clear = 1'b1;
        issue(1, 34'h1010, PMP_ACC_WRITE, PRIV_LVL_U, 1, 1, 0);
        step();
        chk("clrfault_valid", fault_valid, 1);
        chk("clrfault_chan", fault_chan, 1);
        chk("clrfault_addr", fault_addr, 34'h1010);
        chk("clrfault_cnt1", fault_cnt[1], 1);
        chk("clrfault_cnt0", fault_cnt[0], 0);

        // Held response must survive CSR changes while stalled
        rsp_ready[0] = 1'b0;
        issue(0, 34'h1800, PMP_ACC_READ, PRIV_LVL_U, 0, 1, 0);
        @(posedge clk_i);
        #1;
        cfg[0].mode = PMP_MODE_OFF;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", rsp_valid[0], 1);
            chk("hold_req_ready", req_ready[0], 0);
            chk("hold_err", rsp_err[0], 0);
            chk("hold_matched", rsp_matched[0], 1);
            @(posedge clk_i);
            #1;
        end
        rsp_ready[0] = 1'b1;
        q0.push_back({1'b1, 1'b0, 4'd0});
        step();
        chk("hold_new_cnt0", fault_cnt[0], 1);
        chk("hold_log_sticky", fault_addr, 34'h1010);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            issue(0, 34'h1800, PMP_ACC_READ, PRIV_LVL_U, 1, 0, 0);
            @(posedge clk_i);
            #1;
        end
        req_valid = '0;
        chk("sat_cnt0", fault_cnt[0], 255);

        // Debug Module window
        dbg = 1'b1;
        issue(1, 34'h1A110400, PMP_ACC_READ, PRIV_LVL_U, 0, 0, 0);
        issue(0, 34'h1A112000, PMP_ACC_READ, PRIV_LVL_U, 1, 0, 0);
        step();
        dbg = 1'b0;
        step();

        // Reset while a response is pending
        rsp_ready = '0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 34'h1800;
        req_type[0]  = PMP_ACC_READ;
        req_priv[0]  = PRIV_LVL_U;
        @(posedge clk_i);
        #1;
        req_valid = '0;
        chk("midrst_pending", rsp_valid[0], 1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 2'b00);
        chk("midrst_req_ready", req_ready, 2'b11);
        chk("midrst_fault_valid", fault_valid, 0);
        chk("midrst_cnt0", fault_cnt[0], 0);
        rsp_ready = '1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
